// File: rtl/seq_ripple_subtractor_if.sv
// seq_ripple_subtractor_if: operand/result valid-ready bundle; ovf present only with SUB_OVF_EN
interface seq_ripple_subtractor_if #(parameter int N = 8);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic bin;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] d;
  logic bout;
`ifdef SUB_OVF_EN
  logic ovf;
  modport master(output in_valid, x, y, bin, out_ready, input in_ready, out_valid, d, bout, ovf);
  modport slave(input in_valid, x, y, bin, out_ready, output in_ready, out_valid, d, bout, ovf);
`else
  modport master(output in_valid, x, y, bin, out_ready, input in_ready, out_valid, d, bout);
  modport slave(input in_valid, x, y, bin, out_ready, output in_ready, out_valid, d, bout);
`endif
endinterface

// File: rtl/seq_ripple_subtractor.sv
// seq_ripple_subtractor: digit-serial d = x - y - bin, W bits per cycle, LSB first; SUB_OVF_EN adds signed overflow
module seq_ripple_subtractor #(
  parameter int N = 8,
  parameter int W = 2
) (
  input logic clk,
  input logic reset,
  seq_ripple_subtractor_if.slave s
);
  localparam int ITER = N / W;
  localparam int CW = ITER > 1 ? $clog2(ITER) : 1;
  if (N % W != 0) begin : g_chk
    $error("seq_ripple_subtractor: N must be divisible by W");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] xr, yr, dr;
  logic br, bo, b, last;
  logic [CW-1:0] cnt;
  logic [W-1:0] diff;
  logic [31:0] off;
  assign off = 32'(cnt) * 32'(W);
  assign last = cnt == CW'(ITER - 1);
  assign {b, diff} = {1'b0, xr[off +: W]} - {1'b0, yr[off +: W]} - (W + 1)'(br);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && s.in_valid) state_n = RUN;
    else if (state == RUN && last) state_n = DONE;
    else if (state == DONE && s.out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      dr <= '0;
      bo <= 1'b0;
      br <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE && s.in_valid) begin
      xr <= s.x;
      yr <= s.y;
      br <= s.bin;
      cnt <= '0;
    end else if (state == RUN) begin
      dr[off +: W] <= diff;
      br <= b;
      cnt <= cnt + 1'b1;
      if (last) bo <= b;
    end
`ifdef SUB_OVF_EN
  // signed overflow: operand signs differ and the result sign departs from the minuend's
  logic ov;
  always_ff @(posedge clk)
    if (reset) ov <= 1'b0;
    else if (state == RUN && last) ov <= (xr[N-1] != yr[N-1]) && (diff[W-1] != xr[N-1]);
  assign s.ovf = ov;
`endif
  assign s.in_ready = state == IDLE && !reset;
  assign s.out_valid = state == DONE;
  assign s.d = dr;
  assign s.bout = bo;
endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// tb_seq_ripple_subtractor: directed vectors on W=2 plus random sweeps on W=1/4/8 against a scoreboard
module tb_seq_ripple_subtractor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic bin;
    logic [7:0] d;
    logic bout;
    logic ovf;
    int hold;
  } vec_t;
  typedef struct {
    logic [7:0] d;
    logic bout;
    logic ovf;
  } exp_t;

  seq_ripple_subtractor_if #(.N(8)) bus ();
  seq_ripple_subtractor #(.N(8), .W(2)) dut (.clk(clk), .reset(rst_m), .s(bus));

  exp_t sbq[$];

  always @(negedge clk)
    if (!rst_m && bus.out_valid && bus.out_ready) begin
      exp_t e;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got d=%h with nothing pending, required no result", bus.d);
      end else begin
        e = sbq.pop_front();
        chk("d", 32'(bus.d), 32'(e.d));
        chk("bout", 32'(bus.bout), 32'(e.bout));
`ifdef SUB_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end

  task automatic do_op(input vec_t v);
    int lat;
    @(negedge clk);
    lat = 0;
    while (!bus.in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.x = v.x;
    bus.y = v.y;
    bus.bin = v.bin;
    bus.in_valid = 1'b1;
    bus.out_ready = v.hold == 0;
    sbq.push_back('{d: v.d, bout: v.bout, ovf: v.ovf});
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'd4);
    if (v.hold > 0) begin
      for (int h = 0; h < v.hold; h++) begin
        chk("hold_d", 32'(bus.d), 32'(v.d));
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = h == 1;
        bus.x = 8'hAA;
        bus.y = 8'h11;
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    if (v.hold > 0)
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("no_extra_op", 32'(bus.out_valid), 32'd0);
      end
  endtask

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int WW = g == 0 ? 1 : (g == 1 ? 4 : 8);
    localparam int IT = 8 / WW;
    logic done_f = 1'b0;
    exp_t q[$];
    seq_ripple_subtractor_if #(.N(8)) sbus ();
    seq_ripple_subtractor #(.N(8), .W(WW)) u (.clk(clk), .reset(rst_s), .s(sbus));
    initial begin
      int lat;
      logic [7:0] a, b;
      logic c;
      exp_t r, e;
      sbus.in_valid = 1'b0;
      sbus.x = '0;
      sbus.y = '0;
      sbus.bin = 1'b0;
      sbus.out_ready = 1'b1;
      while (rst_s) @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        c = 1'($urandom);
        r.d = a - b - {7'd0, c};
        r.bout = {1'b0, a} < {1'b0, b} + {8'd0, c};
        r.ovf = (a[7] ^ b[7]) & (r.d[7] ^ a[7]);
        @(negedge clk);
        chk("sw_in_ready", 32'(sbus.in_ready), 32'd1);
        sbus.x = a;
        sbus.y = b;
        sbus.bin = c;
        sbus.in_valid = 1'b1;
        q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        sbus.in_valid = 1'b0;
        lat = 0;
        while (!sbus.out_valid && lat < 40) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
        chk("sw_latency", 32'(lat), 32'(IT));
        if (sbus.out_valid && q.size() > 0) begin
          e = q.pop_front();
          chk("sw_d", 32'(sbus.d), 32'(e.d));
          chk("sw_bout", 32'(sbus.bout), 32'(e.bout));
`ifdef SUB_OVF_EN
          chk("sw_ovf", 32'(sbus.ovf), 32'(e.ovf));
`endif
        end
        @(posedge clk);
      end
      done_f = 1'b1;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_s = 1'b0;
  end

  initial begin
    vec_t tbl[7];
    int n;
    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
    tbl[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0};
    tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0};
    tbl[6] = '{8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, 1'b0, 5};
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(posedge clk);
    #1 rst_m = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 7; i++) do_op(tbl[i]);
    @(negedge clk);
    bus.x = 8'h5A;
    bus.y = 8'h3C;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    sbq.push_back('{d: 8'h1E, bout: 1'b0, ovf: 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_m = 1'b1;
    @(posedge clk);
    #1 rst_m = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_d", 32'(bus.d), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    do_op('{8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0});
    n = 0;
    while (!(sw[0].done_f && sw[1].done_f && sw[2].done_f) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (!(sw[0].done_f && sw[1].done_f && sw[2].done_f)) begin
      n_chk++;
      n_fail++;
      $display("FAIL sweep_timeout: got unfinished sweep after %0d cycles, required completion", n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_ripple_subtractor.md
Name: seq_ripple_subtractor

Overview:
- Multi-cycle N-bit subtractor: computes d = x - y - bin.
- Processes one W-bit digit per clock, LSB digit first, with a registered borrow chained between digits.
- Counterpart to the combinational ripple adder in the arithmetic library.
- Used where area matters more than latency; wrapped in a valid/ready handshake on both sides.

Parameters:
- N, 8, operand/result width in bits.
- W, 2, digit width processed per cycle. N must be divisible by W; elaboration error otherwise.
- ITER, N/W (derived, localparam), cycles per operation.

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands x, y, bin valid
- in_ready  output  1  block can accept operands
- x  input  N  minuend
- y  input  N  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- d  output  N  difference, registered
- bout  output  1  borrow-out, registered
- ovf  output  1  signed overflow (only with SUB_OVF_EN)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, d=0, bout=0, out_valid=0, ovf=0, digit counter=0.
- in_ready = (state==IDLE) & ~reset, combinational.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch x, y; borrow register <= bin; cnt <= 0; go to RUN.
- RUN:
  - Each cycle: {b, diff} = x_dig - y_dig - borrow, where dig = bits [cnt*W +: W] (W-bit subtract, b = borrow out of the digit).
  - Write diff into d[cnt*W +: W]; borrow <= b; cnt <= cnt+1.
  - When cnt==ITER-1: bout <= b, go to DONE.
- DONE:
  - out_valid=1; d, bout, ovf held stable.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
- Latency: operands accepted at edge k; out_valid is high after edge k+ITER (ITER RUN cycles).
  - Throughput: one operation per ITER+2 cycles at best. No overlap: in_ready=0 in RUN and DONE, so in_valid is ignored there.
- Arithmetic:
  - Modulo 2^N.
  - bout=1 iff unsigned x < y + bin.
  - d equals (x - y - bin) mod 2^N for all inputs, including bin=1 with y=2^N-1.
- d is only meaningful while out_valid=1. Partial digits are visible in RUN, and the consumer must not sample them.
- out_ready while out_valid=0 has no effect.
- Reset mid-RUN or mid-DONE aborts the operation, restores all reset values on the next edge, and drops the result.
- ITER=1 (W=N) is legal: RUN lasts one cycle.

Optional Feature:
- Macro SUB_OVF_EN.
- Defined:
  - Port ovf exists.
  - On the last RUN cycle: ovf <= (x[N-1] != y[N-1]) & (diff_msb != x[N-1]), i.e. two's-complement signed overflow of x - y - bin.
  - Held in DONE; cleared by reset.
- Not defined: port ovf and its register are absent; all other behaviour is identical.

Test Plan:
- N=8, W=2: x=0x5A, y=0x3C, bin=0, out_ready=1 -> out_valid after 4 cycles, d=0x1E, bout=0, ovf=0; in_ready returns high the next cycle.
- x=0x00, y=0x01, bin=0 -> d=0xFF, bout=1. Then x=0xFF, y=0xFF, bin=1 -> d=0xFF, bout=1.
- x=0x10, y=0x0F, bin=1 -> d=0x00, bout=0. With SUB_OVF_EN: x=0x80, y=0x01, bin=0 -> d=0x7F, bout=0, ovf=1.
- Backpressure: x=0x20, y=0x05, out_ready=0 for 5 cycles after out_valid rises:
  - d=0x1B held stable, in_ready=0.
  - A new in_valid during this window is ignored.
  - After out_ready=1, one transfer occurs and the block returns to IDLE.
- Reset asserted during the 2nd RUN cycle -> next cycle out_valid=0, d=0, bout=0, in_ready=1. A following x=0x03, y=0x01 -> d=0x02.
- Parameter sweep with W=1, W=4, W=8 (N=8), 1000 random operands each -> d, bout (and ovf) match the reference model; latency = ITER every time.
